// File: rtl/gpu_inst_pkg.sv
// Shared definitions for the GPU instruction stream: field widths, assembler
// states and the packed 82-bit instruction word.
package gpu_inst_pkg;

    localparam int unsigned INST_W      = 82;
    localparam int unsigned COORD_W     = 16;
    localparam int unsigned COLOR_W     = 24;
    localparam int unsigned ALPHA_W     = 4;
    localparam int unsigned TEX_W       = 2;
    localparam int unsigned HDR_RSV_LSB = 10;

    typedef enum logic [2:0] {
        HDR,
        COL_LO,
        COL_HI,
        C0,
        C1,
        C2,
        COMMIT
    } asm_state_t;

    // Declared MSB first so bit 0 is inst_type and bits [81:78] are alpha_val.
    typedef struct packed {
        logic [ALPHA_W-1:0] alpha_val;
        logic [TEX_W-1:0]   texture_code;
        logic [COLOR_W-1:0] color_code;
        logic               fill_type;
        logic               layer_num;
        logic [COORD_W-1:0] coord2;
        logic [COORD_W-1:0] coord1;
        logic [COORD_W-1:0] coord0;
        logic               vertice_num;
        logic               inst_type;
    } inst_word_t;

endpackage

// File: rtl/inst_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data_o always presents the head entry,
// written words become visible one cycle after the write (no bypass).
module inst_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = 82
) (
    input  logic         clk_i,
    input  logic         n_rst_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH == 2**AW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/inst_fifo_writer.sv
// Assembles 16-bit host beats into 82-bit instruction words and buffers them
// in a show-ahead FIFO for the main controller and decode logic.
module inst_fifo_writer
    import gpu_inst_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [15:0]       host_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              read_en,
    output logic [INST_W-1:0] fifo_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              proto_err
);

    asm_state_t state_q;
    inst_word_t stage_q;
    logic       ready_q;
    logic       perr_q;
    logic       beat;
    logic       wr_en;

    // ready_q holds host_ready low for the cycle following a reset edge.
    assign host_ready = ready_q && (state_q != COMMIT);
    assign beat       = host_valid && host_ready;
    assign wr_en      = (state_q == COMMIT);
    assign proto_err  = perr_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= HDR;
            stage_q <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            perr_q  <= 1'b0;
            case (state_q)
                HDR: if (beat) begin
                    stage_q.inst_type    <= host_data[0];
                    stage_q.vertice_num  <= host_data[1];
                    stage_q.layer_num    <= host_data[2];
                    stage_q.fill_type    <= host_data[3];
                    stage_q.texture_code <= host_data[5:4];
                    stage_q.alpha_val    <= host_data[9:6];
                    perr_q               <= |host_data[15:HDR_RSV_LSB];
                    state_q              <= COL_LO;
                end
                COL_LO: if (beat) begin
                    stage_q.color_code[15:0] <= host_data;
                    state_q                  <= COL_HI;
                end
                COL_HI: if (beat) begin
                    stage_q.color_code[23:16] <= host_data[7:0];
                    state_q                   <= C0;
                end
                C0: if (beat) begin
                    stage_q.coord0 <= host_data;
                    state_q        <= C1;
                end
                C1: if (beat) begin
                    stage_q.coord1 <= host_data;
                    if (stage_q.vertice_num) begin
                        state_q <= C2;
                    end else begin
                        stage_q.coord2 <= '0;
                        state_q        <= COMMIT;
                    end
                end
                C2: if (beat) begin
                    stage_q.coord2 <= host_data;
                    state_q        <= COMMIT;
                end
                // The FIFO accepts the write on this same edge whenever it is not full.
                COMMIT: if (!fifo_full) state_q <= HDR;
                default: state_q <= HDR;
            endcase
        end
    end

    inst_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (INST_W)
    ) u_fifo (
        .clk_i     (clk),
        .n_rst_i   (n_rst),
        .wr_en_i   (wr_en),
        .wr_data_i (stage_q),
        .rd_en_i   (read_en),
        .rd_data_o (fifo_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

endmodule
